// File: rtl/gigatron_mem_sched.sv
// gigatron_mem_sched: 4-clock frame scheduler sharing one SRAM between core and host.
// Define GIGATRON_HOST_HOLD_EN to let host_hold suppress the core clock enable.
module gigatron_mem_sched #(
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              rst,
  output logic              cpu_ce,
  output logic              cpu_halted,
  input  logic [ADDR_W-1:0] cpu_raddr,
  output logic [7:0]        cpu_rdata,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_we,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  input  logic              host_hold,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  output logic              sram_we,
  input  logic [7:0]        sram_din
);

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_e;

  phase_e            ph_q;
  phase_e            ph_d;
  logic              hold_w;
  logic              cpu_ce_q;
  logic              cpu_halted_q;
  logic [7:0]        cpu_rdata_q;
  logic              host_srv_q;
  logic              host_rd_q;
  logic              host_ack_q;
  logic [7:0]        host_rdata_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [7:0]        sram_dout_q;
  logic              sram_we_q;

`ifdef GIGATRON_HOST_HOLD_EN
  assign hold_w = host_hold;
`else
  logic unused_hold;
  assign unused_hold = host_hold;
  assign hold_w      = 1'b0;
`endif

  always_comb begin
    ph_d = P0;
    unique case (ph_q)
      P0: ph_d = P1;
      P1: ph_d = P2;
      P2: ph_d = P3;
      P3: ph_d = P0;
    endcase
  end

  // Each branch sets up the registered SRAM drive for the phase that follows.
  always_ff @(posedge clock) begin
    if (rst) begin
      ph_q         <= P0;
      cpu_ce_q     <= 1'b0;
      cpu_halted_q <= 1'b0;
      cpu_rdata_q  <= 8'h00;
      host_srv_q   <= 1'b0;
      host_rd_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= 8'h00;
      sram_addr_q  <= '0;
      sram_dout_q  <= 8'h00;
      sram_we_q    <= 1'b0;
    end else begin
      ph_q         <= ph_d;
      cpu_ce_q     <= (ph_q == P2) && !hold_w;
      cpu_halted_q <= (ph_q == P2) && hold_w;
      host_ack_q   <= (ph_q == P2) && host_srv_q;
      unique case (ph_q)
        P3: begin
          sram_we_q  <= cpu_we;
          host_srv_q <= 1'b0;
          host_rd_q  <= 1'b0;
          if (cpu_we) begin
            sram_addr_q <= cpu_waddr;
            sram_dout_q <= cpu_wdata;
          end
          if (host_rd_q) begin
            host_rdata_q <= sram_din;
          end
        end
        P0: begin
          sram_we_q   <= 1'b0;
          sram_addr_q <= cpu_raddr;
        end
        P1: begin
          host_srv_q <= host_req;
          host_rd_q  <= host_req && !host_we;
          sram_we_q  <= host_req && host_we;
          if (host_req) begin
            sram_addr_q <= host_addr;
            sram_dout_q <= host_wdata;
          end
        end
        P2: begin
          cpu_rdata_q <= sram_din;
          sram_we_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ce     = cpu_ce_q;
  assign cpu_halted = cpu_halted_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_ack   = host_ack_q;
  // Host read data arrives from the SRAM during the ack clock itself.
  assign host_rdata = (host_ack_q && host_rd_q) ? sram_din : host_rdata_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dout  = sram_dout_q;
  assign sram_we    = sram_we_q;

endmodule

// File: tb/tb_gigatron_mem_sched.sv
// tb_gigatron_mem_sched: table vectors, random frames against a frame-level
// memory model, and hand sequences for latency, hold and reset corners.
module tb_gigatron_mem_sched;

`ifdef GIGATRON_HOST_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        clock;
  logic        rst;
  logic        cpu_ce;
  logic        cpu_halted;
  logic [14:0] cpu_raddr;
  logic [7:0]  cpu_rdata;
  logic [14:0] cpu_waddr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        host_req;
  logic        host_we;
  logic [14:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_hold;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [14:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_we;
  logic [7:0]  sram_din;

  gigatron_mem_sched #(.ADDR_W(15)) dut (
    .clock      (clock),
    .rst        (rst),
    .cpu_ce     (cpu_ce),
    .cpu_halted (cpu_halted),
    .cpu_raddr  (cpu_raddr),
    .cpu_rdata  (cpu_rdata),
    .cpu_waddr  (cpu_waddr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_hold  (host_hold),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .sram_addr  (sram_addr),
    .sram_dout  (sram_dout),
    .sram_we    (sram_we),
    .sram_din   (sram_din)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] sram_mem [0:32767];
  always @(posedge clock) begin
    if (sram_we) sram_mem[sram_addr] <= sram_dout;
    sram_din <= sram_mem[sram_addr];
  end

  typedef struct {
    logic        we;
    logic [14:0] wa;
    logic [7:0]  wd;
    logic [14:0] ra;
    logic        hreq;
    logic        hwe;
    logic [14:0] ha;
    logic [7:0]  hwd;
    logic        hold;
    logic [7:0]  e_rd;
    logic        e_ack;
    logic [7:0]  e_hr;
  } vec_t;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int ce_seen = 0;
  int halt_seen = 0;
  logic [7:0] ref_mem [0:32767];
  logic [7:0] ref_hr;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic set_idle();
    cpu_we = 0; cpu_waddr = 0; cpu_wdata = 0; cpu_raddr = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    host_hold = 0;
  endtask

  // Frame-level model: core write, then core read, then host access.
  task automatic ref_step(inout vec_t v);
    if (v.we) ref_mem[v.wa] = v.wd;
    v.e_rd = ref_mem[v.ra];
    v.e_ack = v.hreq;
    if (v.hreq) begin
      if (v.hwe) ref_mem[v.ha] = v.hwd;
      else ref_hr = ref_mem[v.ha];
    end
    v.e_hr = ref_hr;
  endtask

  // Called in a P3 cycle; returns in the next P3 cycle.
  task automatic run_frame(input vec_t v);
    logic hx;
    cpu_we = v.we; cpu_waddr = v.wa; cpu_wdata = v.wd; cpu_raddr = v.ra;
    host_req = v.hreq; host_we = v.hwe; host_addr = v.ha;
    host_wdata = v.hwd; host_hold = v.hold;
    tick();
    chk("p0_we", sram_we, v.we);
    if (v.we) begin
      chk("p0_addr", sram_addr, v.wa);
      chk("p0_dout", sram_dout, v.wd);
    end
    chk("p0_ce", cpu_ce, 0);
    tick();
    chk("p1_we", sram_we, 0);
    chk("p1_addr", sram_addr, v.ra);
    tick();
    chk("p2_we", sram_we, v.hreq && v.hwe);
    if (v.hreq) chk("p2_addr", sram_addr, v.ha);
    chk("p2_ack", host_ack, 0);
    tick();
    hx = v.hold && HOLD_EN;
    chk("p3_ce", cpu_ce, !hx);
    chk("p3_halted", cpu_halted, hx);
    ce_seen += int'(cpu_ce);
    halt_seen += int'(cpu_halted);
    chk("cpu_rdata", cpu_rdata, v.e_rd);
    chk("host_ack", host_ack, v.e_ack);
    chk("host_rdata", host_rdata, v.e_hr);
  endtask

  function automatic logic [14:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 15'($urandom_range(0, 32767));
    return 15'($urandom_range(0, 7));
  endfunction

  initial begin
    vec_t v;
    int n;
    int exp_lat;
    logic [14:0] a;
    for (int i = 0; i < 32768; i++) begin
      sram_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    ref_hr = 8'h00;
    set_idle();
    rst = 1;
    //          we wa       wd     ra       hreq hwe ha       hwd    hold e_rd  ack e_hr
    tbl[0] = '{1, 15'h0123, 8'h5A, 15'h0123, 0, 0, 15'h0000, 8'h00, 0, 8'h5A, 0, 8'h00};
    tbl[1] = '{0, 15'h0000, 8'h00, 15'h0123, 1, 1, 15'h7FFF, 8'hA5, 0, 8'h5A, 1, 8'h00};
    tbl[2] = '{0, 15'h0000, 8'h00, 15'h7FFF, 1, 0, 15'h7FFF, 8'h00, 0, 8'hA5, 1, 8'hA5};
    tbl[3] = '{1, 15'h0040, 8'h11, 15'h0040, 1, 1, 15'h0040, 8'h22, 0, 8'h11, 1, 8'hA5};
    tbl[4] = '{0, 15'h0000, 8'h00, 15'h0040, 1, 0, 15'h0040, 8'h00, 0, 8'h22, 1, 8'h22};
    tbl[5] = '{1, 15'h0000, 8'hC3, 15'h0000, 1, 0, 15'h0123, 8'h00, 0, 8'hC3, 1, 8'h5A};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_ce", cpu_ce, 0);
    chk("rst_halted", cpu_halted, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_ack", host_ack, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_dout", sram_dout, 0);
    chk("rst_sram_we", sram_we, 0);

    rst = 0;
    cyc = 0;
    chk("idle_ce", cpu_ce, 0);
    for (int i = 1; i < 12; i++) begin
      tick();
      chk("idle_ce", cpu_ce, (cyc % 4) == 3);
      chk("idle_we", sram_we, 0);
    end

    for (int i = 0; i < 6; i++) begin
      v = tbl[i];
      ref_step(v);
      run_frame(tbl[i]);
    end

    set_idle();
    for (int p = 0; p < 4; p++) begin
      n = 0;
      while ((cyc % 4) != p && n < 8) begin
        tick();
        n++;
      end
      a = 15'(16 + p);
      host_req = 1; host_we = 0; host_addr = a;
      n = 0;
      do begin
        tick();
        n++;
        chk("lat_ce", cpu_ce, (cyc % 4) == 3);
      end while (!host_ack && n < 12);
      exp_lat = (p <= 1) ? 3 - p : 7 - p;
      chk($sformatf("lat_p%0d", p), n, exp_lat);
      ref_hr = ref_mem[a];
      chk("lat_hrdata", host_rdata, ref_hr);
      host_req = 0;
    end

    ce_seen = 0;
    halt_seen = 0;
    for (int f = 0; f < 5; f++) begin
      v = '{default: '0};
      v.hold = (f >= 1 && f <= 3);
      ref_step(v);
      run_frame(v);
    end
    chk("hold_ce_count", ce_seen, HOLD_EN ? 2 : 5);
    chk("hold_halt_count", halt_seen, HOLD_EN ? 3 : 0);

    for (int f = 0; f < 80; f++) begin
      v = '{default: '0};
      v.we = 1'($urandom_range(0, 1));
      v.wa = rnd_addr();
      v.wd = 8'($urandom_range(0, 255));
      v.ra = rnd_addr();
      v.hreq = 1'($urandom_range(0, 1));
      v.hwe = 1'($urandom_range(0, 1));
      v.ha = rnd_addr();
      v.hwd = 8'($urandom_range(0, 255));
      v.hold = ($urandom_range(0, 3) == 0);
      ref_step(v);
      run_frame(v);
    end

    set_idle();
    host_req = 1; host_we = 0; host_addr = 15'h0005;
    tick();
    tick();
    tick();
    rst = 1;
    tick();
    chk("midrst_ack", host_ack, 0);
    chk("midrst_ce", cpu_ce, 0);
    chk("midrst_we", sram_we, 0);
    chk("midrst_cpu_rdata", cpu_rdata, 0);
    chk("midrst_host_rdata", host_rdata, 0);
    tick();
    chk("midrst_ack2", host_ack, 0);
    rst = 0;
    cyc = 0;
    chk("postrst_ack", host_ack, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("postrst_ack", host_ack, cyc == 3);
      chk("postrst_ce", cpu_ce, cyc == 3);
    end
    chk("postrst_hrdata", host_rdata, ref_mem[15'h0005]);
    host_req = 0;
    tick();
    chk("postrst_ack_drop", host_ack, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
